out_bram_reader: RTL and testbench
==================================

// Module: out_bram_reader
// PURPOSE
//  Drains accumulated output psums from the output BRAM after accumulation completes.
//  Reads one byte per element and streams it out over a valid/ready handshake.
//  Optionally applies ReLU, and optionally writes zero back so the next layer starts clean.
//  Sits on the BRAM port opposite the accumulator and feeds the output DMA / next-layer buffer.
// PARAMETERS
//  DATA_WIDTH      8     element width; one byte lane of the BRAM word
//  BRAM_WIDTH      32    BRAM data width
//  BRAM_ADDR_BIT   32    BRAM byte-address width
//  BRAM_BYTE       4     byte enables; equals BRAM_WIDTH/8
//  NO_ENTRY_BIT    16    width of no_entry
//  NO_CHANNEL_BIT  11    width of no_channel
// PORTS
//  clk          in   1               clock; also drives BRAM_clk
//  rst          in   1               synchronous, active-high reset
//  start        in   1               1-cycle pulse; begins a drain (ignored while busy)
//  base_addr    in   BRAM_ADDR_BIT   first byte address; latched on start
//  no_entry     in   NO_ENTRY_BIT    entries per channel; latched on start
//  no_channel   in   NO_CHANNEL_BIT  channel count; latched on start
//  clear_en     in   1               write 0 to each byte after it is sent; latched on start
//  relu_en      in   1               clamp negative (signed) bytes to 0; latched on start
//  out_data     out  DATA_WIDTH      streamed element
//  out_valid    out  1               out_data valid
//  out_ready    in   1               consumer accepts
//  busy         out  1               high from the cycle after start until done
//  done         out  1               1-cycle pulse at end of drain
//  BRAM_addr    out  BRAM_ADDR_BIT   registered byte address
//  BRAM_clk     out  1               = clk
//  BRAM_din     out  BRAM_WIDTH      write data; zero except the cleared lane (also zero)
//  BRAM_dout    in   BRAM_WIDTH      read data
//  BRAM_en      out  1               constant 1
//  BRAM_rst     out  1               constant 0
//  BRAM_wen     out  BRAM_BYTE       byte write enables
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, busy, done, BRAM_wen, BRAM_addr, BRAM_din, out_data all 0.
//  total = no_entry*no_channel (NO_ENTRY_BIT+NO_CHANNEL_BIT bits); element k is at base_addr+k.
//  Lane = BRAM_addr[1:0]; element = BRAM_dout[lane*8 +: 8].
//  FSM:
//   IDLE : on start, latch inputs, cnt=0, addr=base_addr. If total==0 -> DONE with no BRAM
//          access; otherwise -> READ.
//   READ : BRAM_addr<=addr; BRAM_wen<=0 -> WAIT.
//   WAIT : BRAM samples the address -> LATCH.
//   LATCH: out_data<=element (0 if relu_en && element[7]); out_valid<=1 -> OUT.
//          Read latency: 3 cycles from READ entry to out_valid.
//   OUT  : hold out_data/out_valid stable until out_ready. On handshake: out_valid<=0,
//          cnt++, addr++.
//          If clear_en: BRAM_wen[lane]<=1, BRAM_din<=0 -> CLEAR.
//          Otherwise -> DONE if cnt==total-1, else READ.
//   CLEAR: BRAM_wen<=0 (wen high for exactly 1 cycle); -> DONE if last, else READ.
//   DONE : done<=1 for 1 cycle, busy<=0 -> IDLE.
//  busy is high in every state except IDLE and the cycle done is asserted.
//  start while busy is ignored; inputs are sampled only in IDLE.
//  out_ready held high: one element per 4 cycles (5 with clear_en).
//  A cleared byte is never re-read in the same drain; other lanes are untouched (byte wen).
//  rst mid-drain: immediate return to IDLE; wen drops in the same edge; no done pulse;
//  a partially cleared region stays as-is.
//  Addresses wrap modulo 2^BRAM_ADDR_BIT.
// TESTING
//  1 BRAM bytes 0..7 = 1..8; base=0, entry=4, chan=2, ready=1 -> out 1..8 in order, done once, BRAM unchanged.
//  2 Same with clear_en=1 -> same stream; one wen pulse per byte on the correct lane; BRAM bytes 0..7 = 0 after.
//  3 relu_en=1, bytes {0x7F,0x80,0xFF,0x01} -> out 0x7F,0x00,0x00,0x01.
//  4 out_ready toggling randomly -> out_data stable while valid&&!ready; no loss or duplication; 8 handshakes total.
//  5 entry=0 -> done 2 cycles after start, no BRAM_wen, no out_valid; start during busy ignored.
//  6 rst asserted in OUT with clear_en=1 -> next cycle all outputs 0, wen 0, no done; fresh start works.

Source files
------------

// File: rtl/out_bram_reader.sv
// Output-BRAM drain engine: reads one byte per element, streams it over valid/ready,
// optionally clamps negatives to zero and writes zero back to each sent byte.
module out_bram_reader #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BRAM_WIDTH     = 32,
  parameter int unsigned BRAM_ADDR_BIT  = 32,
  parameter int unsigned BRAM_BYTE      = 4,
  parameter int unsigned NO_ENTRY_BIT   = 16,
  parameter int unsigned NO_CHANNEL_BIT = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BRAM_ADDR_BIT-1:0]  base_addr,
  input  logic [NO_ENTRY_BIT-1:0]   no_entry,
  input  logic [NO_CHANNEL_BIT-1:0] no_channel,
  input  logic                      clear_en,
  input  logic                      relu_en,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [BRAM_ADDR_BIT-1:0]  BRAM_addr,
  output logic                      BRAM_clk,
  output logic [BRAM_WIDTH-1:0]     BRAM_din,
  input  logic [BRAM_WIDTH-1:0]     BRAM_dout,
  output logic                      BRAM_en,
  output logic                      BRAM_rst,
  output logic [BRAM_BYTE-1:0]      BRAM_wen
);

  localparam int unsigned CNT_BIT  = NO_ENTRY_BIT + NO_CHANNEL_BIT;
  localparam int unsigned LANE_BIT = $clog2(BRAM_BYTE);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LATCH, S_OUT, S_CLEAR, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_BIT-1:0]       cnt_q, cnt_d;
  logic [CNT_BIT-1:0]       total_q, total_d;
  logic [BRAM_ADDR_BIT-1:0] addr_q, addr_d;
  logic [BRAM_ADDR_BIT-1:0] bram_addr_q, bram_addr_d;
  logic                     clear_q, clear_d;
  logic                     relu_q, relu_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [BRAM_BYTE-1:0]     wen_q, wen_d;

  logic [LANE_BIT-1:0]      lane;
  logic [DATA_WIDTH-1:0]    elem;
  logic                     handshake;

  assign BRAM_clk  = clk;
  assign BRAM_en   = 1'b1;
  assign BRAM_rst  = 1'b0;
  assign BRAM_din  = '0;
  assign BRAM_addr = bram_addr_q;
  assign BRAM_wen  = wen_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign lane      = bram_addr_q[LANE_BIT-1:0];
  assign handshake = out_valid_q & out_ready;

  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < BRAM_BYTE; i++) begin
      if (lane == LANE_BIT'(i)) elem = BRAM_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      total_q     <= '0;
      addr_q      <= '0;
      bram_addr_q <= '0;
      clear_q     <= 1'b0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wen_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      addr_q      <= addr_d;
      bram_addr_q <= bram_addr_d;
      clear_q     <= clear_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wen_q       <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (no_entry == '0 || no_channel == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: state_d = S_OUT;
      S_OUT: begin
        if (handshake) begin
          if (clear_q)                               state_d = S_CLEAR;
          else if (cnt_q == total_q - CNT_BIT'(1))   state_d = S_DONE;
          else                                       state_d = S_READ;
        end
      end
      // cnt was already advanced in OUT, so "last" here means cnt reached total
      S_CLEAR: state_d = (cnt_q == total_q) ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    total_d     = total_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    clear_d     = clear_q;
    relu_d      = relu_q;
    bram_addr_d = bram_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wen_d       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = CNT_BIT'(no_entry) * CNT_BIT'(no_channel);
          cnt_d   = '0;
          addr_d  = base_addr;
          clear_d = clear_en;
          relu_d  = relu_en;
          busy_d  = 1'b1;
        end
      end
      S_READ: bram_addr_d = addr_q;
      S_LATCH: begin
        out_data_d  = (relu_q && elem[DATA_WIDTH-1]) ? '0 : elem;
        out_valid_d = 1'b1;
      end
      S_OUT: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_BIT'(1);
          addr_d      = addr_q + BRAM_ADDR_BIT'(1);
          if (clear_q) wen_d[lane] = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_out_bram_reader.sv
// Directed self-checking bench for out_bram_reader with a byte-addressed BRAM model.
module tb_out_bram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] no_entry = '0;
  logic [10:0] no_channel = '0;
  logic        clear_en = 1'b0;
  logic        relu_en = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout = '0;
  logic        BRAM_en, BRAM_rst;
  logic [3:0]  BRAM_wen;

  always #5 clk = ~clk;

  out_bram_reader #(
    .DATA_WIDTH(8), .BRAM_WIDTH(32), .BRAM_ADDR_BIT(32),
    .BRAM_BYTE(4), .NO_ENTRY_BIT(16), .NO_CHANNEL_BIT(11)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .no_entry(no_entry), .no_channel(no_channel), .clear_en(clear_en),
    .relu_en(relu_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .BRAM_addr(BRAM_addr),
    .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_wen(BRAM_wen)
  );

  int checks = 0;
  int failures = 0;

  // BRAM model: 64 bytes, registered read, byte-enable write, bench preload port
  logic [7:0] mem [64];
  logic       ld_en = 1'b0;
  int         ld_addr = 0;
  logic [7:0] ld_data = '0;
  int         wa;
  always @(posedge clk) begin
    wa = int'({BRAM_addr[5:2], 2'b00});
    BRAM_dout <= {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};
    if (ld_en) mem[ld_addr] <= ld_data;
    else for (int i = 0; i < 4; i++) if (BRAM_wen[i]) mem[wa+i] <= BRAM_din[i*8 +: 8];
  end

  // consumer ready: constant 1, or a fixed irregular pattern
  logic        rdy_mode = 1'b0;
  logic [15:0] pat = 16'b0110_0101_1100_1001;
  logic [3:0]  pidx = '0;
  always @(posedge clk) begin
    #2;
    out_ready = rdy_mode ? pat[pidx] : 1'b1;
    if (rdy_mode) pidx = pidx + 4'd1;
  end

  // monitor
  int         cyc = 0;
  logic [7:0] got [$];
  int         hs_cyc [$];
  logic [31:0] wen_addr [$];
  logic [3:0] wen_val [$];
  int         done_cnt, wen_cnt, valid_cnt, stall_err, done_cyc;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (out_valid) valid_cnt++;
    if (out_valid && out_ready) begin got.push_back(out_data); hs_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (|BRAM_wen) begin wen_cnt++; wen_addr.push_back(BRAM_addr); wen_val.push_back(BRAM_wen); end
    if (stall_pend && (!out_valid || out_data !== stall_data)) stall_err++;
    stall_pend = out_valid && !out_ready;
    stall_data = out_data;
  end

  task automatic clear_mon();
    got.delete(); hs_cyc.delete(); wen_addr.delete(); wen_val.delete();
    done_cnt = 0; wen_cnt = 0; valid_cnt = 0; stall_err = 0; done_cyc = 0;
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] ne, input logic [10:0] nc,
                          input logic clr, input logic rl);
    base_addr = b; no_entry = ne; no_channel = nc; clear_en = clr; relu_en = rl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (BRAM_wen !== 4'h0) begin failures++; $display("FAIL reset_wen: got %h expected 0", BRAM_wen); end
    checks++; if (BRAM_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", BRAM_addr); end
    checks++; if (out_data !== 8'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (BRAM_din !== 32'h0) begin failures++; $display("FAIL reset_din: got %h expected 0", BRAM_din); end
    checks++; if ({BRAM_en, BRAM_rst} !== 2'b10) begin failures++; $display("FAIL reset_en_rst: got %b expected 10", {BRAM_en, BRAM_rst}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    bit ok;
    int lat;
    for (int i = 0; i < 8; i++) load_byte(i, 8'(i + 1));
    for (int i = 8; i < 12; i++) load_byte(i, 8'hAA);
    clear_mon();
    do_start(32'd0, 16'd4, 11'd2, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL stream_latency: got %0d expected 4", lat); end
    wait_done(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stream_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL stream_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) if (i < got.size()) begin
      checks++; if (got[i] !== 8'(i + 1)) begin failures++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got[i], 8'(i + 1)); end
    end
    if (hs_cyc.size() == 8) begin
      checks++; if (hs_cyc[1] - hs_cyc[0] != 4) begin failures++; $display("FAIL stream_rate: got %0d expected 4", hs_cyc[1] - hs_cyc[0]); end
      checks++; if (done_cyc - hs_cyc[7] != 2) begin failures++; $display("FAIL stream_done_lat: got %0d expected 2", done_cyc - hs_cyc[7]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stream_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (wen_cnt != 0) begin failures++; $display("FAIL stream_wen_cnt: got %0d expected 0", wen_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== 8'(i + 1)) begin failures++; $display("FAIL stream_mem[%0d]: got %h expected %h", i, mem[i], 8'(i + 1)); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_clear();
    bit ok;
    logic [3:0] exp_w;
    for (int i = 0; i < 8; i++) load_byte(i, 8'(i + 1));
    clear_mon();
    do_start(32'd0, 16'd4, 11'd2, 1'b1, 1'b0);
    wait_done(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clear_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL clear_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) if (i < got.size()) begin
      checks++; if (got[i] !== 8'(i + 1)) begin failures++; $display("FAIL clear_data[%0d]: got %h expected %h", i, got[i], 8'(i + 1)); end
    end
    checks++; if (wen_cnt != 8) begin failures++; $display("FAIL clear_wen_cnt: got %0d expected 8", wen_cnt); end
    for (int i = 0; i < 8; i++) if (i < wen_cnt) begin
      exp_w = 4'b0001 << (i % 4);
      checks++; if (wen_val[i] !== exp_w || wen_addr[i] !== 32'(i)) begin
        failures++; $display("FAIL clear_wen[%0d]: got wen=%h addr=%h expected wen=%h addr=%h", i, wen_val[i], wen_addr[i], exp_w, 32'(i));
      end
    end
    if (hs_cyc.size() == 8) begin
      checks++; if (hs_cyc[1] - hs_cyc[0] != 5) begin failures++; $display("FAIL clear_rate: got %0d expected 5", hs_cyc[1] - hs_cyc[0]); end
    end
    for (int i = 0; i < 12; i++) begin
      checks++; if (mem[i] !== (i < 8 ? 8'h00 : 8'hAA)) begin failures++; $display("FAIL clear_mem[%0d]: got %h expected %h", i, mem[i], (i < 8 ? 8'h00 : 8'hAA)); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL clear_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_relu();
    bit ok;
    logic [7:0] src [4] = '{8'h7F, 8'h80, 8'hFF, 8'h01};
    logic [7:0] exp_on [4] = '{8'h7F, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) load_byte(16 + i, src[i]);
    for (int pass = 0; pass < 2; pass++) begin
      clear_mon();
      do_start(32'd16, 16'd4, 11'd1, 1'b0, pass == 0);
      wait_done(100, ok);
      checks++; if (!ok || got.size() != 4) begin failures++; $display("FAIL relu_count[%0d]: got %0d expected 4", pass, got.size()); end
      for (int i = 0; i < 4; i++) if (i < got.size()) begin
        checks++; if (got[i] !== (pass == 0 ? exp_on[i] : src[i])) begin
          failures++; $display("FAIL relu_data[%0d][%0d]: got %h expected %h", pass, i, got[i], (pass == 0 ? exp_on[i] : src[i]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < 8; i++) load_byte(i, 8'(i + 1));
    clear_mon();
    rdy_mode = 1'b1;
    do_start(32'd0, 16'd2, 11'd4, 1'b0, 1'b0);
    wait_done(300, ok);
    rdy_mode = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() != 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) if (i < got.size()) begin
      checks++; if (got[i] !== 8'(i + 1)) begin failures++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got[i], 8'(i + 1)); end
    end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_zero();
    clear_mon();
    base_addr = 32'd0; no_entry = 16'd0; no_channel = 11'd3; clear_en = 1'b1; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    no_entry = 16'd2; no_channel = 11'd1;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL zero_cycle1: got busy,done=%b expected 10", {busy, done}); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b01) begin failures++; $display("FAIL zero_cycle2: got busy,done=%b expected 01", {busy, done}); end
    repeat (10) @(posedge clk); #1;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (valid_cnt != 0) begin failures++; $display("FAIL zero_valid: got %0d expected 0", valid_cnt); end
    checks++; if (wen_cnt != 0) begin failures++; $display("FAIL zero_wen: got %0d expected 0", wen_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    clear_mon();
    do_start(32'd0, 16'd1, 11'd1, 1'b0, 1'b0);
    base_addr = 32'd4; no_entry = 16'd4; no_channel = 11'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, ok);
    repeat (12) @(posedge clk); #1;
    checks++; if (!ok) begin failures++; $display("FAIL busy_done_timeout: got 0 expected 1"); end
    checks++; if (got.size() != 1) begin failures++; $display("FAIL busy_count: got %0d expected 1", got.size()); end
    if (got.size() >= 1) begin
      checks++; if (got[0] !== 8'h01) begin failures++; $display("FAIL busy_data: got %h expected 01", got[0]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    bit hit;
    logic [7:0] exp2 [8] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 8; i++) load_byte(i, 8'(i + 1));
    clear_mon();
    do_start(32'd0, 16'd4, 11'd2, 1'b1, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid && wen_cnt >= 1) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_out: got 0 expected 1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, busy, done, BRAM_wen} !== 7'b0) begin
      failures++; $display("FAIL rstmid_ctrl: got valid,busy,done,wen=%b expected 0000000", {out_valid, busy, done, BRAM_wen});
    end
    checks++; if ({BRAM_addr, out_data} !== 40'h0) begin failures++; $display("FAIL rstmid_regs: got addr=%h data=%h expected 0", BRAM_addr, out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    checks++; if (wen_cnt != 1) begin failures++; $display("FAIL rstmid_wen_cnt: got %0d expected 1", wen_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== exp2[i]) begin failures++; $display("FAIL rstmid_mem[%0d]: got %h expected %h", i, mem[i], exp2[i]); end
    end
    clear_mon();
    do_start(32'd0, 16'd4, 11'd2, 1'b0, 1'b0);
    wait_done(100, ok);
    checks++; if (!ok || got.size() != 8) begin failures++; $display("FAIL rstmid_restart_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) if (i < got.size()) begin
      checks++; if (got[i] !== exp2[i]) begin failures++; $display("FAIL rstmid_restart[%0d]: got %h expected %h", i, got[i], exp2[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rstmid_restart_done: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_stream();
    test_clear();
    test_relu();
    test_backpressure();
    test_zero();
    test_busy_ignore();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
